// File: rtl/mem_arbiter_pkg.sv
// Shared CPU memory-side constants: arbiter state encoding, load/store funct3 width
// codes, the I/O address-match constant, and the transfer byte-count helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Address bits [17:16] equal to this select the memory-mapped I/O window.
  localparam logic [1:0] IO_ADDR_MATCH = 2'b11;

  function automatic logic [2:0] byte_count(input logic [2:0] width);
    case (width[1:0])
      2'b00:   byte_count = 3'd1;
      2'b01:   byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word by funct3 width.
module load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [2:0]  i_width,
  output logic [31:0] o_ext
);

  always_comb begin
    o_ext = i_raw;
    case (i_width)
      F3_B:    o_ext = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_H:    o_ext = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_BU:   o_ext = {24'd0, i_raw[7:0]};
      F3_HU:   o_ext = {16'd0, i_raw[15:0]};
      default: o_ext = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch and load/store, round-robin.
// Optional IO_BUFFER_STALL_EN holds I/O-window store bytes while io_buffer_full is set.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_ls,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic [2:0]  lsb_width,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata
);

  // Handshake: requesters hold *_req high until their one-cycle *_done pulse;
  // the DONE cycle never samples requests, so a dropped request is seen in time.
  arb_state_t  r_state;
  arb_state_t  w_next;
  logic [2:0]  r_cnt;
  logic [2:0]  r_n;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_if_hold;
  logic [31:0] r_lsb_hold;
  logic [2:0]  r_width;
  logic        r_is_read;
  logic        r_grant_if;
  logic        r_last_if;

  logic        w_grant;
  logic        w_grant_if;
  logic        w_stall;
  logic        w_done;
  logic [31:0] w_addr;
  logic [31:0] w_ext;
  logic [1:0]  w_idx;

  assign w_addr = r_base + {29'd0, r_cnt};
  assign w_idx  = r_cnt[1:0] - 2'd1;

`ifdef IO_BUFFER_STALL_EN
  assign w_stall = (r_state == ST_WRITE) && (w_addr[17:16] == IO_ADDR_MATCH) && io_buffer_full;
`else
  logic w_unused_io_full;
  assign w_unused_io_full = io_buffer_full;
  assign w_stall = 1'b0;
`endif

  load_extend u_load_extend (
    .i_raw   (r_buf),
    .i_width (r_width),
    .o_ext   (w_ext)
  );

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_grant_if = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rollback && (if_req || lsb_req)) begin
          w_grant    = 1'b1;
          w_grant_if = (if_req && lsb_req) ? !r_last_if : if_req;
          w_next     = (w_grant_if || lsb_ls) ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: begin
        if (rollback)          w_next = ST_IDLE;
        else if (r_cnt == r_n) w_next = ST_DONE;
      end
      ST_WRITE: begin
        if (!w_stall && (r_cnt == r_n - 3'd1)) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // A flushed read loses its done pulse even in its final cycle; stores always complete.
  assign w_done   = (r_state == ST_DONE) && !rst && !(rollback && r_is_read);
  assign if_done  = w_done && r_grant_if;
  assign lsb_done = w_done && !r_grant_if;
  assign if_data  = (w_done && r_grant_if) ? r_buf : r_if_hold;
  assign lsb_rdata = (w_done && !r_grant_if && r_is_read) ? w_ext : r_lsb_hold;

  assign mem_wr   = (r_state == ST_WRITE) && rdy && !rst && !w_stall;
  assign mem_a    = (!rst && (((r_state == ST_READ) && (r_cnt < r_n)) || (r_state == ST_WRITE)))
                    ? w_addr : 32'd0;
  assign mem_dout = (!rst && (r_state == ST_WRITE)) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_n        <= 3'd0;
      r_base     <= 32'd0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
      r_if_hold  <= 32'd0;
      r_lsb_hold <= 32'd0;
      r_width    <= F3_W;
      r_is_read  <= 1'b0;
      r_grant_if <= 1'b0;
      r_last_if  <= 1'b1;
    end else if (rdy) begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_base     <= w_grant_if ? if_addr : lsb_addr;
            r_wdata    <= lsb_wdata;
            r_width    <= w_grant_if ? F3_W : lsb_width;
            r_n        <= w_grant_if ? 3'd4 : byte_count(lsb_width);
            r_is_read  <= w_grant_if || lsb_ls;
            r_grant_if <= w_grant_if;
            r_last_if  <= w_grant_if;
            r_cnt      <= 3'd0;
            r_buf      <= 32'd0;
          end
        end
        ST_READ: begin
          // Byte k arrives the cycle after its address, so capture lags the counter by one.
          if (r_cnt != 3'd0) r_buf[{w_idx, 3'b000} +: 8] <= mem_din;
          r_cnt <= r_cnt + 3'd1;
        end
        ST_WRITE: begin
          if (!w_stall) r_cnt <= r_cnt + 3'd1;
        end
        default: begin
          r_cnt <= 3'd0;
          if (w_done && r_is_read) begin
            if (r_grant_if) r_if_hold  <= r_buf;
            else            r_lsb_hold <= w_ext;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-level RAM model, cycle-indexed logs, assertion checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req = 1'b0;
  logic        lsb_ls = 1'b0;
  logic [31:0] lsb_addr = 32'd0;
  logic [31:0] lsb_wdata = 32'd0;
  logic [2:0]  lsb_width = 3'd0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_ls(lsb_ls), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_width(lsb_width), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cur, n_done, n_wr, done_cyc;
  bit drop_on_done = 1'b1;
  logic [7:0]  ram [logic [31:0]];
  logic [31:0] a_log  [0:63];
  logic        wr_log [0:63];
  logic [7:0]  d_log  [0:63];
  logic [31:0] done_data;
  int          done_cycles [$];
  logic        done_is_if [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: commit any write seen this cycle, move to the next cycle's low phase,
  // return the byte addressed last cycle, and log outputs of the new cycle.
  task automatic tick();
    logic [31:0] a;
    a = mem_a;
    if (mem_wr) begin
      ram[a] = mem_dout;
      n_wr++;
    end
    @(negedge clk);
    cur++;
    mem_din = ram.exists(a) ? ram[a] : 8'd0;
    if (cur < 64) begin
      a_log[cur]  = mem_a;
      wr_log[cur] = mem_wr;
      d_log[cur]  = mem_dout;
    end
    if (if_done || lsb_done) begin
      n_done++;
      done_cyc = cur;
      done_cycles.push_back(cur);
      done_is_if.push_back(if_done);
      done_data = if_done ? if_data : lsb_rdata;
      if (drop_on_done) begin
        if_req  = 1'b0;
        lsb_req = 1'b0;
      end
    end
  endtask

  task automatic run_to(input int last);
    while (cur < last) tick();
  endtask

  task automatic start_test();
    cur = 0; n_done = 0; n_wr = 0; done_cyc = -1;
    done_cycles.delete();
    done_is_if.delete();
  endtask

  task automatic lsb_op(input logic ls, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] width);
    lsb_req = 1'b1; lsb_ls = ls; lsb_addr = addr; lsb_wdata = wdata; lsb_width = width;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int wsum;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h200] = 8'h80; ram[32'h202] = 8'h34; ram[32'h203] = 8'h92;

    // Reset state
    start_test();
    tick();
    tick();
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);
    rst = 1'b0;

    // lw at 0x100
    start_test();
    lsb_op(1'b1, 32'h100, 32'd0, 3'd2);
    run_to(9);
    for (int k = 0; k < 4; k++) chk($sformatf("lw_addr_c%0d", k + 1), a_log[k + 1], 32'h100 + k);
    chk("lw_no_wr", {31'd0, wr_log[1] | wr_log[2] | wr_log[3] | wr_log[4]}, 32'd0);
    chk("lw_done_cyc", done_cyc, 32'd6);
    chk("lw_done_cnt", n_done, 32'd1);
    chk("lw_rdata", done_data, 32'h44332211);
    chk("lw_rdata_held", lsb_rdata, 32'h44332211);

    // lb / lbu / lh
    start_test();
    lsb_op(1'b1, 32'h200, 32'd0, 3'd0);
    run_to(5);
    chk("lb_done_cyc", done_cyc, 32'd3);
    chk("lb_rdata", done_data, 32'hFFFFFF80);
    start_test();
    lsb_op(1'b1, 32'h200, 32'd0, 3'd4);
    run_to(5);
    chk("lbu_rdata", done_data, 32'h00000080);
    start_test();
    lsb_op(1'b1, 32'h202, 32'd0, 3'd1);
    run_to(6);
    chk("lh_done_cyc", done_cyc, 32'd4);
    chk("lh_rdata", done_data, 32'hFFFF9234);

    // sh 0xABCD to 0x300
    start_test();
    lsb_op(1'b0, 32'h300, 32'h0000ABCD, 3'd1);
    run_to(5);
    chk("sh_c1", {wr_log[1], a_log[1][30:0]}, {1'b1, 31'h300});
    chk("sh_c1_data", {24'd0, d_log[1]}, 32'hCD);
    chk("sh_c2", {wr_log[2], a_log[2][30:0]}, {1'b1, 31'h301});
    chk("sh_c2_data", {24'd0, d_log[2]}, 32'hAB);
    chk("sh_done_cyc", done_cyc, 32'd3);
    chk("sh_wr_cnt", n_wr, 32'd2);
    chk("sh_rdata_unchanged", lsb_rdata, 32'h00009234 | 32'hFFFF0000);

    // sw under continuous rollback completes
    start_test();
    lsb_op(1'b0, 32'h500, 32'h11223344, 3'd2);
    tick();
    rollback = 1'b1;
    run_to(7);
    rollback = 1'b0;
    chk("sw_rb_wr_cnt", n_wr, 32'd4);
    chk("sw_rb_done_cyc", done_cyc, 32'd5);
    chk("sw_rb_c4", {wr_log[4], a_log[4][30:0]}, {1'b1, 31'h503});
    chk("sw_rb_ram", {ram[32'h503], ram[32'h502], ram[32'h501], ram[32'h500]}, 32'h11223344);

    // rdy=0 freezes grant and write, and masks mem_wr
    start_test();
    rdy = 1'b0;
    lsb_op(1'b0, 32'h400, 32'h5A, 3'd0);
    tick();
    chk("rdy0_no_grant", {mem_wr, mem_a[30:0]}, 32'd0);
    rdy = 1'b1;
    tick();
    chk("rdy_wr_c2", {mem_wr, mem_a[30:0]}, {1'b1, 31'h400});
    chk("rdy_dout_c2", {24'd0, mem_dout}, 32'h5A);
    rdy = 1'b0;
    #1;
    chk("rdy0_mask_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    rdy = 1'b1;
    #1;
    chk("rdy_frozen_wr", {mem_wr, mem_a[30:0]}, {1'b1, 31'h400});
    run_to(6);
    chk("rdy_done_cyc", done_cyc, 32'd4);
    chk("rdy_wr_cnt", n_wr, 32'd1);

    // rollback in IDLE suppresses the grant
    start_test();
    rollback = 1'b1;
    lsb_op(1'b0, 32'h600, 32'h77, 3'd0);
    tick();
    chk("rb_idle_no_grant", {mem_wr, mem_a[30:0]}, 32'd0);
    rollback = 1'b0;
    run_to(5);
    chk("rb_idle_done_cyc", done_cyc, 32'd3);
    chk("rb_idle_ram", {24'd0, ram[32'h600]}, 32'h77);

    // I/O-window store with io_buffer_full high through cycle 5
    start_test();
    io_buffer_full = 1'b1;
    lsb_op(1'b0, 32'h30000, 32'hC3, 3'd0);
    for (int i = 0; i < 6; i++) tick();
    wsum = 0;
    for (int c = 1; c <= 5; c++) wsum += int'(wr_log[c]);
    io_buffer_full = 1'b0;
    run_to(9);
`ifdef IO_BUFFER_STALL_EN
    chk("io_stall_no_wr", wsum, 32'd0);
    chk("io_stall_done_cyc", done_cyc, 32'd7);
`else
    chk("io_ignore_wr", wsum, 32'd1);
    chk("io_ignore_done_cyc", done_cyc, 32'd2);
`endif
    chk("io_wr_cnt", n_wr, 32'd1);
    chk("io_ram", {24'd0, ram[32'h30000]}, 32'hC3);

    // Round-robin after reset: LSB, IF, LSB
    do_reset();
    start_test();
    drop_on_done = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h100;
    lsb_op(1'b1, 32'h100, 32'd0, 3'd2);
    run_to(20);
    if_req = 1'b0;
    lsb_req = 1'b0;
    drop_on_done = 1'b1;
    run_to(24);
    chk("rr_done_cnt", n_done, 32'd3);
    if (done_cycles.size() == 3) begin
      chk("rr_order", {29'd0, done_is_if[0], done_is_if[1], done_is_if[2]}, 32'b010);
      chk("rr_cyc1", done_cycles[0], 32'd6);
      chk("rr_cyc2", done_cycles[1], 32'd13);
      chk("rr_cyc3", done_cycles[2], 32'd20);
    end
    chk("rr_if_data", if_data, 32'h44332211);

    // rollback in cycle 2 of an IF read
    start_test();
    if_req = 1'b1;
    if_addr = 32'h200;
    tick();
    tick();
    rollback = 1'b1;
    if_req = 1'b0;
    tick();
    rollback = 1'b0;
    chk("rb_if_idle", mem_a, 32'd0);
    run_to(9);
    chk("rb_if_no_done", n_done, 32'd0);
    chk("rb_if_data_held", if_data, 32'h44332211);

    // rst mid-read abandons the transfer
    start_test();
    lsb_op(1'b1, 32'h200, 32'd0, 3'd2);
    tick();
    tick();
    lsb_req = 1'b0;
    do_reset();
    run_to(12);
    chk("rst_mid_no_done", n_done, 32'd0);
    chk("rst_mid_rdata", lsb_rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk input 1 (clock); rst input 1 (synchronous, active-high reset); rdy input 1 (global enable).
REQ-002 SHALL have ports: rollback input 1 (flush); mem_din input 8 (RAM read byte); mem_dout output 8 (RAM write byte); mem_a output 32 (RAM address); mem_wr output 1 (1=write); io_buffer_full input 1.
REQ-003 SHALL have ports: if_req input 1 (level, held until done); if_addr input 32; if_done output 1 (pulse); if_data output 32 (fetched word).
REQ-004 SHALL have ports: lsb_req input 1 (level); lsb_ls input 1 (1=load); lsb_addr input 32; lsb_wdata input 32; lsb_width input 3 (funct3: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu); lsb_done output 1 (pulse); lsb_rdata output 32.

Function
REQ-005 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-006 In IDLE, arbitration SHALL be round-robin: if both requests are pending, the requester not granted last wins; after reset LSB wins.
REQ-007 Byte count SHALL be 1/2/4 for width[1:0]=0/1/2; IF always 4; byte k SHALL use address base+k, little-endian.
REQ-008 READ SHALL drive mem_a=base+k, mem_wr=0 in the k-th READ cycle; mem_din SHALL be captured one cycle later as byte k.
REQ-009 Read latency SHALL be fixed: grant at edge of cycle 0, addresses in cycles 1..n, done pulse in cycle n+2 (lw/IF: done in cycle 6).
REQ-010 WRITE SHALL drive mem_wr=1, mem_a=base+k, mem_dout=wdata[8k+7:8k] in the k-th WRITE cycle; done pulse in cycle n+1.
REQ-011 DONE SHALL last exactly one cycle, assert the granted requester's done, and sample no new request; return to IDLE after it.
REQ-012 lsb_rdata SHALL be sign-extended for widths 0/1 and zero-extended for 4/5; it SHALL be valid in the done cycle and held until the next done.
REQ-013 if_data SHALL be valid in the if_done cycle and held until the next done.
REQ-014 mem_wr SHALL be 0 in all states other than WRITE and whenever rdy=0.
REQ-015 rdy=0 SHALL freeze all state, counters and outputs (except mem_wr per REQ-014).
REQ-016 rollback=1 during READ or DONE of any read SHALL go to IDLE at the next edge with no done pulse.
REQ-017 rollback=1 during WRITE SHALL NOT abort it; the committed store SHALL complete and pulse lsb_done.
REQ-018 rollback in IDLE SHALL suppress the grant in that cycle.
REQ-019 Address arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-020 rst SHALL force: state IDLE, mem_wr 0, mem_a 0, mem_dout 0, if_done 0, lsb_done 0, if_data 0, lsb_rdata 0, byte counter 0, last-grant=IF.
REQ-021 rst mid-transfer SHALL abandon it with no done pulse; rst SHALL take priority over rdy.

Configuration
REQ-022 With macro IO_BUFFER_STALL_EN defined, a WRITE byte whose address has [17:16]=2'b11 SHALL be held (mem_wr=0, counter frozen) while io_buffer_full=1, then issue when it clears.
REQ-023 Without IO_BUFFER_STALL_EN, io_buffer_full SHALL be ignored.

Structure
REQ-024 State encodings, funct3 width codes, and the I/O address-match constant SHALL live in the shared CPU constants package/header.
REQ-025 Sign/zero extension SHALL be one combinational sub-module, load_extend; there SHALL be no other sub-module.

Verification
REQ-026 lw at 0x100 with RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 in cycles 1-4; lsb_done in cycle 6; lsb_rdata=0x44332211.
REQ-027 lb at 0x200 with byte 0x80 -> lsb_rdata=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-028 sh 0xABCD to 0x300 -> mem_wr=1 with (0x300,CD) then (0x301,AB); lsb_done in cycle 3.
REQ-029 if_req and lsb_req held together -> grants alternate LSB, IF, LSB across three transfers; one done per transfer.
REQ-030 rollback in cycle 2 of an IF read -> IDLE next cycle, no if_done; rollback during sw -> all 4 bytes written, lsb_done pulses.
REQ-031 With IO_BUFFER_STALL_EN, sb to 0x30000 while io_buffer_full=1 for 5 cycles -> mem_wr stays 0 for those 5 cycles, then one write of the byte and lsb_done.
